// File: rtl/sobel_stream_core_if.sv
// Pixel-in / edge-out stream bundle for sobel_stream_core.
// Handshake: a beat transfers on a rising clock edge where valid && ready are
// both high. The producer holds payload stable while valid && !ready, and
// valid never depends combinationally on ready.
interface sobel_stream_core_if #(
  parameter int PIX_W = 8
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [PIX_W-1:0] in_pix_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [PIX_W-1:0] out_pix_o;
  logic             out_last_o;
  logic             frame_done_o;

  // Pixel source and edge-map sink side
  modport master (
    output in_valid_i, in_pix_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_pix_o, out_last_o, frame_done_o
  );

  // Edge engine side
  modport slave (
    input  in_valid_i, in_pix_i, out_ready_i,
    output in_ready_o, out_valid_o, out_pix_o, out_last_o, frame_done_o
  );
endinterface

// File: rtl/sobel_stream_core.sv
// Streaming 3x3 Sobel edge engine. Raster pixels enter through two line
// buffers and a 3x3 window; every interior pixel leaves as either a binary
// edge flag or a saturated |Gx|+|Gy| magnitude. A single registered output
// stage gives one cycle of latency and full-rate throughput.
module sobel_stream_core #(
  parameter int IMG_W       = 256,
  parameter int IMG_H       = 256,
  parameter int PIX_W       = 8,
  parameter int MAG_W       = PIX_W + 3,
  parameter int THR_DEFAULT = 150
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [MAG_W-1:0] thr_i,
  input  logic             mode_i,
  sobel_stream_core_if.slave bus
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int SW = MAG_W + 1;
  localparam logic [MAG_W-1:0] PIX_MAX = MAG_W'((1 << PIX_W) - 1);

  // Raster position of the next pixel to be accepted
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  // Per-frame configuration, captured with pixel (0,0)
  logic [MAG_W-1:0] thr_q, thr_d;
  logic             mode_q, mode_d;
  // Output stage
  logic             out_valid_q, out_valid_d;
  logic [PIX_W-1:0] out_pix_q, out_pix_d;
  logic             out_last_q, out_last_d;
  logic             frame_done_q, frame_done_d;
  // Left and middle window columns; the right column is the incoming one
  logic [PIX_W-1:0] win_q [3][2];
  logic [PIX_W-1:0] win_d [3][2];
  // lb_top holds row-2, lb_mid holds row-1, both indexed by column
  logic [PIX_W-1:0] lb_top_mem [IMG_W];
  logic [PIX_W-1:0] lb_mid_mem [IMG_W];

  logic             in_ready;
  logic             accept;
  logic             emit;
  logic             col_last;
  logic             row_last;
  logic [PIX_W-1:0] new_top, new_mid, new_bot;
  logic [PIX_W-1:0] p00, p01, p02, p10, p12, p20, p21, p22;
  logic signed [SW-1:0] gx, gy;
  logic [MAG_W-1:0] gx_abs, gy_abs, mag;
  logic [PIX_W-1:0] result;

  function automatic logic signed [SW-1:0] ext(input logic [PIX_W-1:0] v);
    return $signed({{(SW-PIX_W){1'b0}}, v});
  endfunction

  // Handshake, raster position flags and the full 3x3 neighbourhood
  always_comb begin
    in_ready = !out_valid_q || bus.out_ready_i;
    accept   = bus.in_valid_i && in_ready;
    col_last = (col_q == CW'(IMG_W - 1));
    row_last = (row_q == RW'(IMG_H - 1));
    emit     = accept && (row_q >= RW'(2)) && (col_q >= CW'(2));
    new_top  = lb_top_mem[col_q];
    new_mid  = lb_mid_mem[col_q];
    new_bot  = bus.in_pix_i;
    p00 = win_q[0][0];
    p01 = win_q[0][1];
    p02 = new_top;
    p10 = win_q[1][0];
    p12 = new_mid;
    p20 = win_q[2][0];
    p21 = win_q[2][1];
    p22 = new_bot;
  end

  // Sobel gradients, magnitude and the mode-dependent result
  always_comb begin
    gx = (ext(p02) + (ext(p12) <<< 1) + ext(p22))
       - (ext(p00) + (ext(p10) <<< 1) + ext(p20));
    gy = (ext(p20) + (ext(p21) <<< 1) + ext(p22))
       - (ext(p00) + (ext(p01) <<< 1) + ext(p02));
    gx_abs = gx[SW-1] ? MAG_W'(-gx) : MAG_W'(gx);
    gy_abs = gy[SW-1] ? MAG_W'(-gy) : MAG_W'(gy);
    mag    = gx_abs + gy_abs;
    if (mode_q) begin
      result = (mag > PIX_MAX) ? '1 : mag[PIX_W-1:0];
    end else begin
      result = (mag > thr_q) ? '1 : '0;
    end
  end

  // Next-state: raster counters, frame config latch, window shift, output stage
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    thr_d        = thr_q;
    mode_d       = mode_q;
    win_d        = win_q;
    out_valid_d  = out_valid_q;
    out_pix_d    = out_pix_q;
    out_last_d   = out_last_q;
    frame_done_d = out_valid_q && bus.out_ready_i && out_last_q;

    if (accept) begin
      if ((col_q == '0) && (row_q == '0)) begin
        thr_d  = thr_i;
        mode_d = mode_i;
      end
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      win_d[0][0] = win_q[0][1];
      win_d[1][0] = win_q[1][1];
      win_d[2][0] = win_q[2][1];
      win_d[0][1] = new_top;
      win_d[1][1] = new_mid;
      win_d[2][1] = new_bot;
    end

    if (emit) begin
      out_valid_d = 1'b1;
      out_pix_d   = result;
      out_last_d  = row_last && col_last;
    end else if (bus.out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  // Control and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col_q        <= '0;
      row_q        <= '0;
      thr_q        <= MAG_W'(THR_DEFAULT);
      mode_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_pix_q    <= '0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      thr_q        <= thr_d;
      mode_q       <= mode_d;
      out_valid_q  <= out_valid_d;
      out_pix_q    <= out_pix_d;
      out_last_q   <= out_last_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Window and line-buffer storage; contents are don't-care after reset
  always_ff @(posedge clk_i) begin
    win_q <= win_d;
    if (accept) begin
      lb_top_mem[col_q] <= new_mid;
      lb_mid_mem[col_q] <= new_bot;
    end
  end

  assign bus.in_ready_o   = in_ready;
  assign bus.out_valid_o  = out_valid_q;
  assign bus.out_pix_o    = out_pix_q;
  assign bus.out_last_o   = out_last_q;
  assign bus.frame_done_o = frame_done_q;

endmodule

// File: tb/tb_sobel_stream_core.sv
// Bench for sobel_stream_core on an 8x6 image: directed and random frames
// scored against a plain-arithmetic Sobel model of the whole image.
module tb_sobel_stream_core;
  localparam int W    = 8;
  localparam int H    = 6;
  localparam int PW   = 8;
  localparam int MW   = PW + 3;
  localparam int NOUT = (W - 2) * (H - 2);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [MW-1:0] thr_i;
  logic mode_i;
  always #5 clk = ~clk;

  sobel_stream_core_if #(.PIX_W(PW)) bus ();

  sobel_stream_core #(
    .IMG_W(W), .IMG_H(H), .PIX_W(PW), .MAG_W(MW), .THR_DEFAULT(150)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .thr_i(thr_i), .mode_i(mode_i), .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  logic [PW:0] exp_q[$];       // {last, pix}
  int img [H][W];
  bit bp_en = 1'b0;
  int beats = 0;
  int done_cnt = 0;
  int frames_sent = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void push_expected(input int thr, input bit mode);
    int gx, gy, mag, o;
    for (int r = 1; r <= H - 2; r++) begin
      for (int c = 1; c <= W - 2; c++) begin
        gx = (img[r-1][c+1] + 2*img[r][c+1] + img[r+1][c+1])
           - (img[r-1][c-1] + 2*img[r][c-1] + img[r+1][c-1]);
        gy = (img[r+1][c-1] + 2*img[r+1][c] + img[r+1][c+1])
           - (img[r-1][c-1] + 2*img[r-1][c] + img[r-1][c+1]);
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        if (mode) o = (mag > 255) ? 255 : mag;
        else      o = (mag > thr) ? 255 : 0;
        exp_q.push_back({(r == H - 2 && c == W - 2), PW'(o)});
      end
    end
  endfunction

  function automatic void fill_const(input int v);
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = v;
  endfunction

  function automatic void fill_step();
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = (c < 4) ? 0 : 100;
  endfunction

  function automatic void fill_rand(input int hi);
    for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = $urandom_range(0, hi);
  endfunction

  // ---------------- driver ----------------
  // Sends the first npix pixels of img; thr/mode are presented with pixel 0
  // and deliberately corrupted halfway through the frame.
  task automatic send_frame(input int thr, input bit mode, input bit gaps, input int npix);
    int tries;
    bit acc;
    push_expected(thr, mode);
    for (int idx = 0; idx < npix; idx++) begin
      tries = 0;
      while (1) begin
        @(negedge clk);
        if (idx == 0) begin
          thr_i  = MW'(thr);
          mode_i = mode;
        end else if (idx == W * H / 2) begin
          thr_i  = ~MW'(thr);
          mode_i = ~mode;
        end
        bus.in_valid_i = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
        bus.in_pix_i   = PW'(img[idx / W][idx % W]);
        #2;
        acc = bus.in_valid_i && bus.in_ready_o;
        @(posedge clk);
        if (acc) break;
        tries++;
        if (tries > 200) begin
          chk("accept_timeout", 1, 0);
          return;
        end
      end
    end
    if (npix == W * H) frames_sent++;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid_i = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 2000; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    chk("drain", exp_q.size(), 0);
    repeat (2) @(posedge clk);
  endtask

  // ---------------- sink + scoreboard ----------------
  initial begin : monitor
    bit stall_prev;
    bit done_pend;
    logic [PW-1:0] pix_prev;
    logic [PW:0] e;
    stall_prev = 1'b0;
    done_pend  = 1'b0;
    pix_prev   = '0;
    bus.out_ready_i = 1'b1;
    forever begin
      @(negedge clk);
      bus.out_ready_i = bp_en ? ($urandom_range(0, 2) != 0) : 1'b1;
      #2;
      if (!rst_n) begin
        stall_prev = 1'b0;
        done_pend  = 1'b0;
        continue;
      end
      chk("in_ready", bus.in_ready_o, !(bus.out_valid_o && !bus.out_ready_i));
      chk("frame_done", bus.frame_done_o, done_pend);
      if (bus.frame_done_o) done_cnt++;
      if (stall_prev) begin
        chk("hold_valid", bus.out_valid_o, 1);
        chk("hold_pix", bus.out_pix_o, pix_prev);
      end
      done_pend = 1'b0;
      if (bus.out_valid_o && bus.out_ready_i) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("pix", bus.out_pix_o, e[PW-1:0]);
          chk("last", bus.out_last_o, e[PW]);
          beats++;
          if (e[PW]) begin
            chk("beats_per_frame", beats, NOUT);
            beats = 0;
            done_pend = 1'b1;
          end
        end
      end
      stall_prev = bus.out_valid_o && !bus.out_ready_i;
      pix_prev   = bus.out_pix_o;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin : stimulus
    bus.in_valid_i = 1'b0;
    bus.in_pix_i   = '0;
    thr_i  = '0;
    mode_i = 1'b0;
    rst_n  = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid_o, 0);
    chk("rst_out_pix", bus.out_pix_o, 0);
    chk("rst_out_last", bus.out_last_o, 0);
    chk("rst_frame_done", bus.frame_done_o, 0);
    chk("rst_in_ready", bus.in_ready_o, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Flat image: no edges anywhere
    fill_const(77);
    send_frame(150, 1'b0, 1'b0, W * H);
    idle();
    drain();

    // Vertical step, magnitude then binary, back-to-back
    fill_step();
    send_frame(0, 1'b1, 1'b0, W * H);
    send_frame(150, 1'b0, 1'b0, W * H);
    idle();
    drain();

    // Threshold boundary around mag 400
    send_frame(400, 1'b0, 1'b0, W * H);
    send_frame(399, 1'b0, 1'b0, W * H);
    idle();
    drain();

    // Same random frame unstalled, then with backpressure and input gaps
    fill_rand(255);
    send_frame(300, 1'b0, 1'b0, W * H);
    idle();
    drain();
    bp_en = 1'b1;
    send_frame(300, 1'b0, 1'b1, W * H);
    idle();
    drain();

    // Random frames, random config, stalled
    for (int k = 0; k < 4; k++) begin
      fill_rand((k % 2 == 0) ? 40 : 255);
      send_frame($urandom_range(0, 2040), 1'($urandom_range(0, 1)), 1'b1, W * H);
    end
    idle();
    drain();

    // Reset after 20 accepted pixels, then a clean frame
    bp_en = 1'b0;
    fill_rand(255);
    send_frame(200, 1'b1, 1'b0, 20);
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", bus.out_valid_o, 0);
    repeat (2) @(negedge clk);
    exp_q.delete();
    beats = 0;
    rst_n = 1'b1;
    fill_rand(255);
    send_frame(250, 1'b0, 1'b0, W * H);
    idle();
    drain();

    // Back-to-back random frames under backpressure
    bp_en = 1'b1;
    fill_rand(60);
    send_frame($urandom_range(0, 2040), 1'b1, 1'b1, W * H);
    fill_rand(255);
    send_frame($urandom_range(0, 600), 1'b0, 1'b1, W * H);
    idle();
    drain();
    bp_en = 1'b0;

    repeat (3) @(posedge clk);
    chk("frame_done_count", done_cnt, frames_sent);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
